earom_nvram_server: RTL and testbench
=====================================

Name: earom_nvram_server

Overview:
- Holds the 64-byte EAROM image (high scores, options) in block RAM.
- Serves it to the HPS over the ioctl upload path (ioctl_rd -> ioctl_din) so the frontend can save NVRAM.
- Restores it from an ioctl download on index NV_INDEX.
- Raises a save request after the game has modified the image and then stopped writing for a quiet period.
- Sits beside the game core in the emu top level, on the same clk_sys domain as hps_io.

Parameters:
ADDR_W, 6, EAROM address width; DEPTH = 2**ADDR_W bytes
NV_INDEX, 8'd4, ioctl_index value that selects NVRAM transfers
QUIET_CYC, 24'd5_000_000, idle cycles after the last game write before save_req pulses
FILL_BYTE, 8'hFF, value returned for upload addresses >= DEPTH

Ports:
clk_sys  in  1  system clock (clk_50 domain in the top level)
reset  in  1  synchronous, active-high reset
ioctl_upload  in  1  HPS upload in progress
ioctl_download  in  1  HPS download in progress
ioctl_index  in  8  transfer index
ioctl_addr  in  25  byte address of the transfer
ioctl_rd  in  1  upload read strobe, one cycle
ioctl_wr  in  1  download write strobe, one cycle
ioctl_dout  in  8  download data
ioctl_din  out  8  upload data to HPS
ioctl_wait  out  1  holds HPS off while a read is pending
game_we  in  1  game EAROM write strobe
game_addr  in  ADDR_W  game read/write address
game_wdata  in  8  game write data
game_rdata  out  8  game read data, registered, 1-cycle latency
save_req  out  1  one-cycle pulse requesting an HPS NVRAM save
dirty  out  1  image modified since last load or save

Behaviour:
- sel = (ioctl_index == NV_INDEX). up_act = ioctl_upload & sel. dl_act = ioctl_download & sel.
- Reset values:
  - ioctl_din = 0, ioctl_wait = 0, save_req = 0, dirty = 0, quiet counter = 0, FSM = IDLE.
  - RAM contents are not cleared.
  - game_rdata is undefined until the first read after reset.
- FSM states: IDLE, FETCH, LATCH.
  - IDLE -> FETCH: on ioctl_rd & up_act. Capture ioctl_addr. Drive RAM port B address = addr[ADDR_W-1:0]. Assert ioctl_wait in the same cycle, combinational from the strobe.
  - FETCH -> LATCH: RAM output becomes valid.
  - LATCH -> IDLE: ioctl_din <= (captured addr >= DEPTH) ? FILL_BYTE : RAM data. ioctl_wait deasserts.
  - Result: ioctl_din is valid 2 cycles after ioctl_rd, and ioctl_wait is high for exactly those 2 cycles.
  - ioctl_rd arriving outside IDLE is ignored. HPS honours ioctl_wait, so this is a protocol error only.
- Download writes:
  - ioctl_wr & dl_act with ioctl_addr < DEPTH writes ioctl_dout to RAM port B in the same cycle.
  - Writes at addresses >= DEPTH are discarded.
  - Non-matching indices are ignored entirely.
- Game port (RAM port A):
  - Reads are always serviced.
  - Writes are blocked (dropped) while up_act or dl_act, so the image stays consistent during transfer.
  - On the same cycle as a download write to the same address, the download wins.
- Dirty flag and save request:
  - An accepted game write sets dirty and reloads the quiet counter to QUIET_CYC.
  - While dirty and not up_act, the counter decrements each cycle. On reaching 1 it pulses save_req for one cycle, and the counter holds at 0.
  - dirty clears on the falling edge of up_act (save complete) or of dl_act (fresh image loaded).
  - A game write during the quiet window restarts the count.
  - No second save_req is issued until dirty is set again and a new quiet window expires.
- Reset mid-operation: FSM aborts to IDLE and ioctl_wait drops the cycle after reset. A partial download leaves RAM partially written. This is acceptable; the frontend retries.
- Port B muxing: upload FETCH and download write never coincide, because HPS runs one transfer type at a time. Download takes priority if both occur.

Decomposition:
- Package bz_nvram_pkg: FSM state enum (IDLE, FETCH, LATCH); default NV_INDEX; FILL_BYTE; QUIET_CYC.
- Sub-module nvram_dpram: true dual-port DEPTH x 8 RAM.
  - Registered outputs.
  - Port A for the game, port B for ioctl.
  - No reset on contents.
- Top block contains the FSM, write arbitration, and dirty/save logic.

Test Plan:
- Download 64 bytes 0x00..0x3F on index 4, then upload with ioctl_rd at addr 0..63 -> ioctl_din = addr value, each valid 2 cycles after its rd, and ioctl_wait high for exactly 2 cycles.
- Upload read at addr 0x40 and 0x1FF -> ioctl_din = 0xFF. A download on index 0 (ROM) -> RAM unchanged, and game read of addr 5 returns 0x05.
- Game write 0xA5 to addr 3 with QUIET_CYC=100 -> dirty = 1, save_req pulses once at cycle 100 after the write. A second write at cycle 50 delays the pulse to cycle 150.
- Game write during active upload -> dropped: re-reading addr 3 returns the old value and dirty is unchanged. The upload falling edge clears dirty.
- Same-cycle download write (0x11) and game write (0x22) to addr 7 -> addr 7 = 0x11.
- Reset asserted in FETCH -> ioctl_wait = 0 the next cycle, FSM IDLE. A subsequent read completes normally.

Source files
------------

// File: rtl/earom_nvram_server_pkg.sv
// Shared types and default constants for the EAROM NVRAM server.
// The upload FSM state is exported so checkers can observe it directly.
package bz_nvram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2
    } nv_state_e;

    localparam int          IOCTL_ADDR_W   = 25;
    localparam logic [7:0]  NV_INDEX_DEF   = 8'd4;
    localparam logic [7:0]  FILL_BYTE_DEF  = 8'hFF;
    localparam logic [23:0] QUIET_CYC_DEF  = 24'd5_000_000;

endpackage

// File: rtl/earom_nvram_server_if.sv
// HPS ioctl transfer bundle as seen by the NVRAM server.
// Handshake: a one-cycle ioctl_rd is accepted when ioctl_wait is low; ioctl_wait
// rises combinationally with the accepted strobe and ioctl_din is valid once it drops.
interface earom_nvram_server_if;
    import bz_nvram_pkg::*;

    logic                    ioctl_upload;
    logic                    ioctl_download;
    logic [7:0]              ioctl_index;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic                    ioctl_rd;
    logic                    ioctl_wr;
    logic [7:0]              ioctl_dout;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_download, ioctl_index, ioctl_addr,
               ioctl_rd, ioctl_wr, ioctl_dout,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_download, ioctl_index, ioctl_addr,
               ioctl_rd, ioctl_wr, ioctl_dout,
        output ioctl_din, ioctl_wait
    );

endinterface

// File: rtl/earom_nvram_server_dpram.sv
// True dual-port DEPTH x 8 RAM with registered read data and no content reset.
// Port A serves the game, port B the ioctl path; callers never write one address from both ports.
module nvram_dpram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [7:0]        wdata_a,
    output logic [7:0]        rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [7:0]        wdata_b,
    output logic [7:0]        rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/earom_nvram_server.sv
// EAROM image holder: serves/restores the image over hps ioctl and requests a
// save once the game has modified it and then stayed quiet for QUIET_CYC cycles.
module earom_nvram_server
    import bz_nvram_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [7:0]  NV_INDEX  = NV_INDEX_DEF,
    parameter logic [23:0] QUIET_CYC = QUIET_CYC_DEF,
    parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEF
) (
    input  logic                clk_sys,
    input  logic                reset,
    earom_nvram_server_if.slave ioctl,
    input  logic                game_we,
    input  logic [ADDR_W-1:0]   game_addr,
    input  logic [7:0]          game_wdata,
    output logic [7:0]          game_rdata,
    output logic                save_req,
    output logic                dirty,
    output nv_state_e           state_dbg
);

    logic              sel;
    logic              up_act;
    logic              dl_act;
    logic              addr_in_range;
    logic [ADDR_W-1:0] addr_b;
    logic              we_b;
    logic              game_ok;
    logic              we_a;
    logic [7:0]        rdata_b;

    assign sel           = (ioctl.ioctl_index == NV_INDEX);
    assign up_act        = ioctl.ioctl_upload & sel;
    assign dl_act        = ioctl.ioctl_download & sel;
    assign addr_in_range = (ioctl.ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0);
    assign addr_b        = ioctl.ioctl_addr[ADDR_W-1:0];
    assign we_b          = ioctl.ioctl_wr & dl_act & addr_in_range;

    // Game writes are frozen for the whole transfer; the address guard keeps the download winning on a clash.
    assign game_ok = game_we & ~up_act & ~dl_act;
    assign we_a    = game_ok & ~(we_b & (addr_b == game_addr));

    nvram_dpram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk_sys),
        .we_a    (we_a),
        .addr_a  (game_addr),
        .wdata_a (game_wdata),
        .rdata_a (game_rdata),
        .we_b    (we_b),
        .addr_b  (addr_b),
        .wdata_b (ioctl.ioctl_dout),
        .rdata_b (rdata_b)
    );

    nv_state_e   state_q, state_d;
    logic        oob_q, oob_d;
    logic [7:0]  din_q, din_d;
    logic        wait_c;

    always_comb begin
        state_d = state_q;
        oob_d   = oob_q;
        din_d   = din_q;
        wait_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ioctl.ioctl_rd && up_act) begin
                    wait_c  = 1'b1;
                    oob_d   = ~addr_in_range;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Port B data registered at the strobe edge is valid in this cycle.
                wait_c  = 1'b1;
                din_d   = oob_q ? FILL_BYTE : rdata_b;
                state_d = LATCH;
            end
            LATCH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic        up_act_q, dl_act_q;
    logic        dirty_q, dirty_d;
    logic [23:0] cnt_q, cnt_d;
    logic        save_q, save_d;
    logic        xfer_done;

    assign xfer_done = (up_act_q & ~up_act) | (dl_act_q & ~dl_act);

    always_comb begin
        dirty_d = dirty_q;
        cnt_d   = cnt_q;
        save_d  = 1'b0;
        if (game_ok) begin
            dirty_d = 1'b1;
            cnt_d   = QUIET_CYC;
        end else if (xfer_done) begin
            dirty_d = 1'b0;
            cnt_d   = '0;
        end else if (dirty_q && !up_act && (cnt_q != '0)) begin
            save_d = (cnt_q == 24'd1);
            cnt_d  = cnt_q - 24'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            oob_q    <= 1'b0;
            din_q    <= 8'h00;
            up_act_q <= 1'b0;
            dl_act_q <= 1'b0;
            dirty_q  <= 1'b0;
            cnt_q    <= '0;
            save_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            oob_q    <= oob_d;
            din_q    <= din_d;
            up_act_q <= up_act;
            dl_act_q <= dl_act;
            dirty_q  <= dirty_d;
            cnt_q    <= cnt_d;
            save_q   <= save_d;
        end
    end

    assign ioctl.ioctl_din  = din_q;
    assign ioctl.ioctl_wait = wait_c;
    assign save_req         = save_q;
    assign dirty            = dirty_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_earom_nvram_server.sv
// Directed bench for earom_nvram_server: drivers push expected results into
// queues, and a negedge monitor pops and compares whenever the DUT presents data.
module tb_earom_nvram_server;
    import bz_nvram_pkg::*;

    localparam int ADDR_W = 6;

    logic              clk_sys;
    logic              reset;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [7:0]        game_wdata;
    logic [7:0]        game_rdata;
    logic              save_req;
    logic              dirty;
    nv_state_e         state_dbg;

    earom_nvram_server_if nv_if ();

    earom_nvram_server #(
        .ADDR_W    (ADDR_W),
        .NV_INDEX  (8'd4),
        .QUIET_CYC (24'd100),
        .FILL_BYTE (8'hFF)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ioctl      (nv_if),
        .game_we    (game_we),
        .game_addr  (game_addr),
        .game_wdata (game_wdata),
        .game_rdata (game_rdata),
        .save_req   (save_req),
        .dirty      (dirty),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  game_q[$];
    logic [31:0] save_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   wait_cnt = 0;
    logic game_tag = 1'b0;
    logic game_tag_p = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset) begin
            wait_cnt   = 0;
            game_tag_p = 1'b0;
        end else begin
            if (nv_if.ioctl_wait) begin
                wait_cnt++;
            end else if (wait_cnt != 0) begin
                check("ioctl_wait_len", wait_cnt, 2);
                if (exp_q.size() == 0) check("ioctl_din_unexpected", 1, 0);
                else check("ioctl_din", {24'h0, nv_if.ioctl_din}, {24'h0, exp_q.pop_front()});
                wait_cnt = 0;
            end
            if (game_tag_p) begin
                if (game_q.size() == 0) check("game_rdata_unexpected", 1, 0);
                else check("game_rdata", {24'h0, game_rdata}, {24'h0, game_q.pop_front()});
            end
            game_tag_p = game_tag;
            if (save_req) begin
                if (save_q.size() == 0) check("save_req_unexpected", 1, 0);
                else check("save_req_cycle", cyc, save_q.pop_front());
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk_sys);
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic dl_write(input logic [24:0] addr, input logic [7:0] data);
        nv_if.ioctl_addr = addr;
        nv_if.ioctl_dout = data;
        nv_if.ioctl_wr   = 1'b1;
        tick(1);
        nv_if.ioctl_wr   = 1'b0;
    endtask

    task automatic up_read(input logic [24:0] addr, input logic [7:0] exp);
        nv_if.ioctl_addr = addr;
        nv_if.ioctl_rd   = 1'b1;
        exp_q.push_back(exp);
        tick(1);
        nv_if.ioctl_rd   = 1'b0;
        tick(3);
    endtask

    task automatic game_write(input logic [ADDR_W-1:0] addr, input logic [7:0] data, output int w);
        w          = cyc;
        game_addr  = addr;
        game_wdata = data;
        game_we    = 1'b1;
        tick(1);
        game_we    = 1'b0;
    endtask

    task automatic game_read(input logic [ADDR_W-1:0] addr, input logic [7:0] exp);
        game_addr = addr;
        game_q.push_back(exp);
        game_tag  = 1'b1;
        tick(1);
        game_tag  = 1'b0;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w1, w2, w3, wx;

        reset                = 1'b1;
        nv_if.ioctl_upload   = 1'b0;
        nv_if.ioctl_download = 1'b0;
        nv_if.ioctl_index    = 8'd0;
        nv_if.ioctl_addr     = '0;
        nv_if.ioctl_rd       = 1'b0;
        nv_if.ioctl_wr       = 1'b0;
        nv_if.ioctl_dout     = 8'h00;
        game_we              = 1'b0;
        game_addr            = '0;
        game_wdata           = 8'h00;
        tick(4);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_ioctl_wait", {31'h0, nv_if.ioctl_wait}, 0);
        check("rst_ioctl_din", {24'h0, nv_if.ioctl_din}, 0);
        check("rst_save_req", {31'h0, save_req}, 0);
        check("rst_dirty", {31'h0, dirty}, 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        tick(1);

        // download 0x00..0x3F on the NVRAM index
        nv_if.ioctl_index    = 8'd4;
        nv_if.ioctl_download = 1'b1;
        for (int a = 0; a < 64; a++) dl_write(25'(a), 8'(a));
        nv_if.ioctl_download = 1'b0;
        tick(2);

        // upload every byte back plus two out-of-range addresses
        nv_if.ioctl_upload = 1'b1;
        tick(1);
        for (int a = 0; a < 64; a++) up_read(25'(a), 8'(a));
        up_read(25'h040, 8'hFF);
        up_read(25'h1FF, 8'hFF);
        nv_if.ioctl_upload = 1'b0;
        tick(2);

        // download on a ROM index must not touch the image
        nv_if.ioctl_index    = 8'd0;
        nv_if.ioctl_download = 1'b1;
        dl_write(25'd5, 8'hEE);
        dl_write(25'd3, 8'h33);
        nv_if.ioctl_download = 1'b0;
        nv_if.ioctl_index    = 8'd4;
        tick(1);
        game_read(6'd5, 8'h05);
        game_read(6'd3, 8'h03);
        @(negedge clk_sys);
        check("dirty_before_write", {31'h0, dirty}, 0);
        tick(1);

        // single write: save_req fires once after the quiet window
        game_write(6'd3, 8'hA5, w1);
        save_q.push_back(32'(w1 + 101));
        @(negedge clk_sys);
        check("dirty_after_write", {31'h0, dirty}, 1);
        tick(140);
        check("save_q_drained_1", save_q.size(), 0);
        check("dirty_after_save_req", {31'h0, dirty}, 1);

        // second write inside the window restarts the count
        game_write(6'd3, 8'h5A, w2);
        tick(49);
        game_write(6'd3, 8'hA5, w3);
        check("restart_offset", w3 - w2, 50);
        save_q.push_back(32'(w3 + 101));
        tick(130);
        check("save_q_drained_2", save_q.size(), 0);
        game_read(6'd3, 8'hA5);

        // game writes are dropped during an upload; its falling edge clears dirty
        nv_if.ioctl_upload = 1'b1;
        tick(1);
        game_write(6'd3, 8'h77, wx);
        @(negedge clk_sys);
        check("dirty_during_upload", {31'h0, dirty}, 1);
        tick(1);
        game_read(6'd3, 8'hA5);
        nv_if.ioctl_upload = 1'b0;
        tick(1);
        @(negedge clk_sys);
        check("dirty_after_upload", {31'h0, dirty}, 0);
        tick(1);

        // same-cycle download and game write to one address: download wins
        nv_if.ioctl_download = 1'b1;
        nv_if.ioctl_addr     = 25'd7;
        nv_if.ioctl_dout     = 8'h11;
        nv_if.ioctl_wr       = 1'b1;
        game_addr            = 6'd7;
        game_wdata           = 8'h22;
        game_we              = 1'b1;
        tick(1);
        nv_if.ioctl_wr       = 1'b0;
        game_we              = 1'b0;
        nv_if.ioctl_download = 1'b0;
        tick(1);
        game_read(6'd7, 8'h11);
        @(negedge clk_sys);
        check("dirty_after_collision", {31'h0, dirty}, 0);
        tick(1);

        // reset while in FETCH aborts the read
        nv_if.ioctl_upload = 1'b1;
        tick(1);
        nv_if.ioctl_addr = 25'd9;
        nv_if.ioctl_rd   = 1'b1;
        tick(1);
        nv_if.ioctl_rd   = 1'b0;
        reset            = 1'b1;
        @(negedge clk_sys);
        check("fetch_state_before_reset", 32'(state_dbg), 32'(FETCH));
        tick(1);
        reset = 1'b0;
        @(negedge clk_sys);
        check("abort_ioctl_wait", {31'h0, nv_if.ioctl_wait}, 0);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_ioctl_din", {24'h0, nv_if.ioctl_din}, 0);
        tick(1);
        up_read(25'd9, 8'h09);
        up_read(25'd7, 8'h11);
        nv_if.ioctl_upload = 1'b0;
        tick(4);

        check("exp_q_empty", exp_q.size(), 0);
        check("game_q_empty", game_q.size(), 0);
        check("save_q_empty", save_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
